// File: rtl/bw_row_sequencer_if.sv
// Operand/product handshake bundle for the row-serial Baugh-Wooley multiplier.
// The producer of operands and consumer of the product sit on the master side.
interface bw_row_sequencer_if #(parameter int N = 8);
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] p;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, p, out_valid
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, p, out_valid
  );
endinterface

// File: rtl/bw_row_sequencer.sv
// Sequential signed NxN Baugh-Wooley multiplier: one partial-product row per clock
// into a 2N-bit accumulator, result presented on a valid/ready output.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready high
// S_ROW  | adding row r_row of the Baugh-Wooley array into r_acc
// S_DONE | product held on p, out_valid high until out_ready
module bw_row_sequencer #(
  parameter int N = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  bw_row_sequencer_if.slave io_bus
);

  localparam int RW = $clog2(N);
  localparam logic [RW-1:0]  C_LAST     = RW'(N - 1);
  localparam logic [2*N-1:0] C_ONE      = {{(2*N-1){1'b0}}, 1'b1};
  // Baugh-Wooley correction: +2^N and +2^(2N-1) fold the sign terms into NANDs.
  localparam logic [2*N-1:0] C_ACC_INIT = (C_ONE << N) | (C_ONE << (2*N-1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROW  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [RW-1:0]  r_row;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_ar;
  logic [N-1:0]   r_br;
  logic [2*N-1:0] r_p;

  logic           w_accept;
  logic           w_last_row;
  logic [N-1:0]   w_row_bits;
  logic [2*N-1:0] w_row_ext;
  logic [2*N-1:0] w_acc_sum;

  assign w_last_row = (r_row == C_LAST);

  // Row cells match the Brown_Box array: NAND where exactly one sign bit is involved.
  always_comb begin
    w_row_bits = '0;
    for (int j = 0; j < N; j++) begin
      if (w_last_row) begin
        if (j == N - 1) w_row_bits[j] = r_ar[j] & r_br[N-1];
        else            w_row_bits[j] = ~(r_ar[j] & r_br[N-1]);
      end else begin
        if (j == N - 1) w_row_bits[j] = ~(r_ar[j] & r_br[r_row]);
        else            w_row_bits[j] = r_ar[j] & r_br[r_row];
      end
    end
  end

  assign w_row_ext = {{N{1'b0}}, w_row_bits};
  assign w_acc_sum = r_acc + (w_row_ext << r_row);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ROW;
        end
      end
      S_ROW: begin
        if (w_last_row) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (io_bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
      r_acc <= '0;
      r_ar  <= '0;
      r_br  <= '0;
      r_p   <= '0;
    end else if (w_accept) begin
      r_ar  <= io_bus.a;
      r_br  <= io_bus.b;
      r_acc <= C_ACC_INIT;
      r_row <= '0;
    end else if (r_state == S_ROW) begin
      r_acc <= w_acc_sum;
      r_row <= r_row + 1'b1;
      if (w_last_row) r_p <= w_acc_sum;
    end
  end

  assign io_bus.in_ready  = (r_state == S_IDLE);
  assign io_bus.out_valid = (r_state == S_DONE);
  assign io_bus.p         = r_p;

endmodule
